// File: rtl/mux_arb_pkg.sv
// ============================================================================
//  Module   : mux_arb_pkg
//  Purpose  : Shared types, requester indices and select encodings for the
//             round-robin 3:1 mux arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package mux_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_C = 2'd2;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;

    function automatic logic [1:0] sel_of(input logic [1:0] idx);
        logic [1:0] sel;
        case (idx)
            REQ_B:   sel = SEL_B;
            REQ_C:   sel = SEL_C;
            default: sel = SEL_A;
        endcase
        return sel;
    endfunction

    function automatic logic [2:0] onehot_of(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            REQ_B:   oh = 3'b010;
            REQ_C:   oh = 3'b100;
            default: oh = 3'b001;
        endcase
        return oh;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin pick: first set request scanning
//             last+1, last+2, last+3 (mod 3).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic       found_o,
    output logic [1:0] idx_o
);

    logic [1:0] w_ord [3];

    // The last entry is the previous winner itself, so a lone requester is re-picked.
    always_comb begin
        w_ord[0] = REQ_A;
        w_ord[1] = REQ_B;
        w_ord[2] = REQ_C;
        case (last_i)
            REQ_A: begin
                w_ord[0] = REQ_B; w_ord[1] = REQ_C; w_ord[2] = REQ_A;
            end
            REQ_B: begin
                w_ord[0] = REQ_C; w_ord[1] = REQ_A; w_ord[2] = REQ_B;
            end
            default: begin
                w_ord[0] = REQ_A; w_ord[1] = REQ_B; w_ord[2] = REQ_C;
            end
        endcase
    end

    always_comb begin
        found_o = 1'b0;
        idx_o   = REQ_A;
        for (int k = 0; k < 3; k++) begin
            if (!found_o && req_i[w_ord[k]]) begin
                found_o = 1'b1;
                idx_o   = w_ord[k];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
// ============================================================================
//  Module   : mux_rr_arbiter
//  Purpose  : Round-robin burst arbiter driving the select pair and data of a
//             shared 3:1 output path with a valid/ready handshake.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] data_c,
    output logic [2:0]       grant,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [3:0] C_LAST_BEAT = 4'(BURST - 1);

    arb_state_e  state_q;
    logic [2:0]  grant_q;
    logic [1:0]  sel_q;
    logic [1:0]  gidx_q;
    logic [1:0]  last_q;
    logic [3:0]  beat_q;

    logic        w_found;
    logic [1:0]  w_idx;
    logic [1:0]  w_last;
    logic        w_xfer;
    logic        w_release;

    // On release the pointer used for the re-pick is the grant being released.
    assign w_last = (state_q == BUSY) ? gidx_q : last_q;

    rr_pick u_pick (
        .req_i   (req),
        .last_i  (w_last),
        .found_o (w_found),
        .idx_o   (w_idx)
    );

    assign out_valid = (state_q == BUSY) && |(req & grant_q);
    assign w_xfer    = out_valid && out_ready;
    assign w_release = (state_q == BUSY) &&
                       ((w_xfer && (beat_q == C_LAST_BEAT)) || !(|(req & grant_q)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
            sel_q   <= SEL_A;
            gidx_q  <= REQ_A;
            last_q  <= REQ_C;
            beat_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_found) begin
                        state_q <= BUSY;
                        gidx_q  <= w_idx;
                        grant_q <= onehot_of(w_idx);
                        sel_q   <= sel_of(w_idx);
                        beat_q  <= 4'd0;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        last_q <= gidx_q;
                        beat_q <= 4'd0;
                        if (w_found) begin
                            gidx_q  <= w_idx;
                            grant_q <= onehot_of(w_idx);
                            sel_q   <= sel_of(w_idx);
                        end else begin
                            state_q <= IDLE;
                            grant_q <= 3'b000;
                            sel_q   <= SEL_A;
                        end
                    end else if (w_xfer) begin
                        beat_q <= beat_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant = grant_q;
    assign s1    = sel_q[1];
    assign s0    = sel_q[0];
    assign y     = sel_q[1] ? data_c : (sel_q[0] ? data_b : data_a);

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// ============================================================================
//  Module   : tb_mux_rr_arbiter
//  Purpose  : Self-checking bench for mux_rr_arbiter (BURST=4 and BURST=2).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux_rr_arbiter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       req;
    logic [WIDTH-1:0] data_a, data_b, data_c;
    logic             out_ready;

    logic [2:0]       grant, grant2;
    logic             s1, s0, s1_2, s0_2;
    logic [WIDTH-1:0] y, y2;
    logic             out_valid, out_valid2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.WIDTH(WIDTH), .BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .data_a(data_a), .data_b(data_b), .data_c(data_c),
        .grant(grant), .s1(s1), .s0(s0), .y(y),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_rr_arbiter #(.WIDTH(WIDTH), .BURST(2)) dut2 (
        .clk(clk), .rst(rst), .req(req),
        .data_a(data_a), .data_b(data_b), .data_c(data_c),
        .grant(grant2), .s1(s1_2), .s0(s0_2), .y(y2),
        .out_valid(out_valid2), .out_ready(out_ready)
    );

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic       rdy;
        logic [2:0] g;
        logic [1:0] sel;
        logic       v;
        logic [3:0] y;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        data_a = 4'h3; data_b = 4'hA; data_c = 4'h5;
        rst = 1'b1; req = 3'b111; out_ready = 1'b1;
        tick();

        // Each row: inputs applied, outputs expected before the next edge.
        vt[0]  = '{1'b1, 3'b111, 1'b1, 3'b000, 2'b00, 1'b0, 4'h3};
        vt[1]  = '{1'b1, 3'b111, 1'b1, 3'b000, 2'b00, 1'b0, 4'h3};
        vt[2]  = '{1'b0, 3'b000, 1'b1, 3'b000, 2'b00, 1'b0, 4'h3};
        vt[3]  = '{1'b0, 3'b111, 1'b1, 3'b000, 2'b00, 1'b0, 4'h3};
        vt[4]  = '{1'b0, 3'b010, 1'b1, 3'b001, 2'b00, 1'b0, 4'h3};
        vt[5]  = '{1'b0, 3'b010, 1'b1, 3'b010, 2'b01, 1'b1, 4'hA};
        vt[6]  = '{1'b0, 3'b010, 1'b1, 3'b010, 2'b01, 1'b1, 4'hA};
        vt[7]  = '{1'b0, 3'b010, 1'b1, 3'b010, 2'b01, 1'b1, 4'hA};
        vt[8]  = '{1'b0, 3'b010, 1'b1, 3'b010, 2'b01, 1'b1, 4'hA};
        vt[9]  = '{1'b0, 3'b010, 1'b1, 3'b010, 2'b01, 1'b1, 4'hA};
        vt[10] = '{1'b0, 3'b000, 1'b1, 3'b010, 2'b01, 1'b0, 4'hA};
        vt[11] = '{1'b0, 3'b000, 1'b1, 3'b000, 2'b00, 1'b0, 4'h3};

        for (int i = 0; i < 12; i++) begin
            rst = vt[i].rst; req = vt[i].req; out_ready = vt[i].rdy;
            #1;
            chk($sformatf("vec%0d grant", i), 32'(grant), 32'(vt[i].g));
            chk($sformatf("vec%0d sel", i), 32'({s1, s0}), 32'(vt[i].sel));
            chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vt[i].v));
            chk($sformatf("vec%0d y", i), 32'(y), 32'(vt[i].y));
            tick();
        end

        // Rotation with BURST=2: A,A,B,B,C,C,A,A.
        begin
            logic [2:0] exp_g [8];
            logic [1:0] exp_s [8];
            exp_g = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
            exp_s = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
            rst = 1'b1; req = 3'b111; out_ready = 1'b1;
            tick();
            rst = 1'b0;
            tick();
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("rot%0d grant", i), 32'(grant2), 32'(exp_g[i]));
                chk($sformatf("rot%0d sel", i), 32'({s1_2, s0_2}), 32'(exp_s[i]));
                chk($sformatf("rot%0d valid", i), 32'(out_valid2), 32'd1);
                tick();
            end
        end

        // Backpressure on C: counter must hold, then exactly 4 beats.
        rst = 1'b1; req = 3'b100; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        req = 3'b101;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp%0d grant", i), 32'(grant), 32'h4);
            chk($sformatf("bp%0d valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d y", i), 32'(y), 32'h5);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("bpx%0d grant", i), 32'(grant), 32'h4);
            tick();
        end
        chk("bp release grant", 32'(grant), 32'h1);
        chk("bp release sel", 32'({s1, s0}), 32'h0);

        // Early drop of A after one beat.
        rst = 1'b1; req = 3'b011; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("drop grantA", 32'(grant), 32'h1);
        tick();
        req = 3'b010;
        #1;
        chk("drop valid", 32'(out_valid), 32'd0);
        tick();
        chk("drop grantB", 32'(grant), 32'h2);
        chk("drop y", 32'(y), 32'hA);

        // Reset in the middle of B's burst resets the priority pointer.
        tick();
        rst = 1'b1; req = 3'b110;
        tick();
        chk("midrst grant", 32'(grant), 32'h0);
        chk("midrst valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("midrst regrant B", 32'(grant), 32'h2);
        chk("midrst sel", 32'({s1, s0}), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
